ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- Execute-to-memory stage placed directly downstream of the ALU.
- Consumes the ALU result and flags for the instruction in EX, and resolves branches and jumps. The predict-not-taken policy is fixed.
- Computes the control-transfer target and produces a one-cycle redirect to fetch.
- Registers the instruction into the EX/MEM pipeline register behind a valid/ready handshake, with flush support.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX holds a valid instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  32  PC of the EX instruction.
- in_imm  in  32  sign-extended immediate.
- in_alu_result  in  32  ALU result.
- in_alu_zero  in  1  ALU zero flag.
- in_alu_overflow  in  1  ALU overflow flag.
- in_store_data  in  32  rs2 value, forwarded.
- in_rd  in  5  destination register.
- in_funct3  in  3  branch condition select.
- in_is_branch, in_is_jal, in_is_jalr  in  1 each  control-transfer class; at most one is set.
- in_mem_read, in_mem_write, in_reg_write  in  1 each  downstream controls.
- flush  in  1  kill from an older stage (MEM trap).
- out_valid  out  1  EX/MEM register holds a valid instruction.
- out_ready  in  1  MEM consumes.
- out_result  out  32  ALU result, or PC+4 for jumps.
- out_store_data  out  32  registered store data.
- out_rd  out  5  registered destination register.
- out_mem_read, out_mem_write, out_reg_write  out  1 each  registered controls.
- out_misaligned  out  1  instruction-address-misaligned exception tag.
- redirect_valid  out  1  one-cycle pulse.
- redirect_pc  out  32  fetch target.

Behaviour:
- Reset: every output register goes to 0 (out_valid, all out_* data/control, redirect_valid, redirect_pc). in_ready reads 1 after reset.
- Handshake:
  - in_ready = !out_valid || out_ready. No combinational path from in_valid to in_ready.
  - Accept = in_valid && in_ready.
  - On accept, the EX/MEM register loads on the next edge. Latency is 1 cycle.
  - If out_valid && !out_ready, all out_* hold stable.
  - If out_ready and there is no accept, out_valid clears.
- Branch condition, evaluated only when in_is_branch:
  - funct3 000 BEQ: taken = zero. 001 BNE: taken = !zero. The ALU performs SUB for both.
  - 100 BLT: taken = result[31]^overflow. 101 BGE: taken = its inverse. The ALU performs SUB for both.
  - 110 BLTU: taken = result[0]. 111 BGEU: taken = !result[0]. The ALU performs SLTU for both.
  - funct3 010 or 011: not taken, no exception.
- Target:
  - Branch and JAL: in_pc + in_imm, modulo 2^32.
  - JALR: in_alu_result with bit 0 forced to 0. The ALU computes rs1+imm.
  - JAL and JALR are always taken.
- Result mux: out_result = in_pc + 4 for JAL/JALR (wraps at 2^32); otherwise in_alu_result.
- Misaligned target: a taken transfer whose target[1] = 1 is misaligned. Then:
  - No redirect is issued.
  - out_misaligned = 1.
  - out_reg_write, out_mem_read and out_mem_write are forced to 0.
  - out_valid = 1, so MEM raises the trap.
- Redirect:
  - On accept of a taken, aligned transfer, redirect_valid = 1 on the next cycle only, with redirect_pc = target.
  - The pulse is independent of out_ready and fires exactly once per instruction, even if MEM then stalls.
  - Otherwise redirect_valid = 0; redirect_pc holds its last value.
- Flush:
  - Clears out_valid on the next edge and cancels any redirect that would be produced on that edge.
  - An input accepted in the same cycle is discarded.
  - Flush has priority over accept and redirect.
  - A redirect already visible in the flush cycle is not retracted.
- Reset mid-operation: asynchronous clear of out_valid and redirect_valid. No partial state survives.

Test Plan:
- Reset, then ALU op: rst pulse, then accept in_alu_result=0x0000_0012, rd=5, reg_write=1 -> next cycle out_valid=1, out_result=0x12, out_rd=5, redirect_valid=0.
- BEQ taken: pc=0x100, imm=0x20, funct3=000, zero=1 -> redirect_valid high for exactly 1 cycle, redirect_pc=0x120, out_reg_write=0. With zero=0 -> no redirect.
- BLT overflow case: funct3=100, result=0x7FFF_FFFF, overflow=1 -> taken. BLTU: funct3=110, result=0 -> not taken.
- JALR with misalignment: pc=0x200, alu_result=0x0000_0305 -> target 0x304, redirect, out_result=0x204. With alu_result=0x306 -> no redirect, out_misaligned=1, out_reg_write=0.
- Backpressure: hold out_ready=0 for 3 cycles after a taken JAL -> in_ready=0 and outputs stable for those 3 cycles, redirect pulse occurs once. Release -> out_valid drops.
- Flush with accept: in_valid, a taken branch, and flush all high in the same cycle -> out_valid=0 and redirect_valid=0 next cycle. Async rst asserted mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: resolves branches/jumps under predict-not-taken, issues a one-cycle
// fetch redirect and registers the instruction behind a valid/ready handshake.
module ex_mem_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_alu_result,
   input  logic            in_alu_zero,
   input  logic            in_alu_overflow,
   input  logic [XLEN-1:0] in_store_data,
   input  logic [4:0]      in_rd,
   input  logic [2:0]      in_funct3,
   input  logic            in_is_branch,
   input  logic            in_is_jal,
   input  logic            in_is_jalr,
   input  logic            in_mem_read,
   input  logic            in_mem_write,
   input  logic            in_reg_write,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [XLEN-1:0] out_store_data,
   output logic [4:0]      out_rd,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic            out_reg_write,
   output logic            out_misaligned,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   logic            accept_p0;
   logic            cond_p0;
   logic            taken_p0;
   logic            misaligned_p0;
   logic            redirect_p0;
   logic [XLEN-1:0] target_p0;
   logic [XLEN-1:0] result_p0;

   // Signed compares come from SUB (sign ^ overflow); unsigned ones from SLTU (bit 0).
   function automatic logic branch_cond(input logic [2:0]      f3,
                                        input logic            zero,
                                        input logic            ovf,
                                        input logic [XLEN-1:0] res);
      logic lt;
      lt = res[XLEN-1] ^ ovf;
      case (f3)
         3'b000:  return zero;
         3'b001:  return !zero;
         3'b100:  return lt;
         3'b101:  return !lt;
         3'b110:  return res[0];
         3'b111:  return !res[0];
         default: return 1'b0;
      endcase
   endfunction

   assign in_ready  = !out_valid || out_ready;
   assign accept_p0 = in_valid && in_ready;

   // Stage p0: EX-side resolution of the incoming instruction
   always_comb begin
      cond_p0       = branch_cond(in_funct3, in_alu_zero, in_alu_overflow, in_alu_result);
      taken_p0      = in_is_jal || in_is_jalr || (in_is_branch && cond_p0);
      target_p0     = in_is_jalr ? {in_alu_result[XLEN-1:1], 1'b0} : in_pc + in_imm;
      misaligned_p0 = taken_p0 && target_p0[1];
      redirect_p0   = taken_p0 && !misaligned_p0;
      result_p0     = (in_is_jal || in_is_jalr) ? in_pc + XLEN'(4) : in_alu_result;
   end

   // Stage p1: EX/MEM register and redirect pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid      <= 1'b0;
         out_result     <= '0;
         out_store_data <= '0;
         out_rd         <= '0;
         out_mem_read   <= 1'b0;
         out_mem_write  <= 1'b0;
         out_reg_write  <= 1'b0;
         out_misaligned <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else if (flush) begin
         out_valid      <= 1'b0;
         redirect_valid <= 1'b0;
      end else if (accept_p0) begin
         out_valid      <= 1'b1;
         out_result     <= result_p0;
         out_store_data <= in_store_data;
         out_rd         <= in_rd;
         // A misaligned transfer travels on only to raise the trap in MEM.
         out_mem_read   <= in_mem_read  && !misaligned_p0;
         out_mem_write  <= in_mem_write && !misaligned_p0;
         out_reg_write  <= in_reg_write && !misaligned_p0;
         out_misaligned <= misaligned_p0;
         redirect_valid <= redirect_p0;
         if (redirect_p0)
            redirect_pc <= target_p0;
      end else begin
         redirect_valid <= 1'b0;
         if (out_ready)
            out_valid <= 1'b0;
      end
   end

endmodule
